// File: rtl/RVS192_package.sv
// Shared RVS192 types: memory access type, LSU sequencer states and misalignment helpers.
package RVS192_package;

    typedef enum logic [2:0] {
        MT_B  = 3'b000,
        MT_H  = 3'b001,
        MT_W  = 3'b010,
        MT_BU = 3'b100,
        MT_HU = 3'b101
    } mem_type;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } lsu_state_t;

    // An access is misaligned when it would cross a word boundary.
    function automatic logic lsu_misaligned(input mem_type t, input logic [1:0] off);
        case (t)
            MT_H, MT_HU: lsu_misaligned = (off == 2'd3);
            MT_W:        lsu_misaligned = (off != 2'd0);
            default:     lsu_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lsu_base_be(input mem_type t);
        case (t)
            MT_H, MT_HU: lsu_base_be = 4'h3;
            MT_W:        lsu_base_be = 4'hF;
            default:     lsu_base_be = 4'h1;
        endcase
    endfunction

endpackage

// File: rtl/RVS192_user_parameters.sv
// Core-wide datapath sizing shared by all RVS192 units.
package RVS192_user_parameters;
    localparam int DATA_LENGTH = 32;
endpackage

// File: rtl/DataGen.sv
// Sign/zero extension of right-justified load data according to the access type.
// Purely combinational, no handshake.
module DataGen
    import RVS192_package::*;
    import RVS192_user_parameters::*;
(
    input  mem_type                  mem_type_i,
    input  logic [DATA_LENGTH-1:0]   data_i,
    output logic [DATA_LENGTH-1:0]   data_o
);

    always_comb begin
        data_o = data_i;
        case (mem_type_i)
            MT_B:    data_o = {{(DATA_LENGTH-8){data_i[7]}}, data_i[7:0]};
            MT_H:    data_o = {{(DATA_LENGTH-16){data_i[15]}}, data_i[15:0]};
            MT_BU:   data_o = {{(DATA_LENGTH-8){1'b0}}, data_i[7:0]};
            MT_HU:   data_o = {{(DATA_LENGTH-16){1'b0}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one access at a time as one or two word bus transactions; aligned access responds 3 cycles after acceptance.
// Stalls the pipeline until done; LSU_MISALIGN_SPLIT_EN splits misaligned accesses, otherwise they trap one cycle after acceptance.
module lsu_ctrl
    import RVS192_package::*;
    import RVS192_user_parameters::*;
#(
    parameter int ADDR_LENGTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  mem_type                 req_type,
    input  logic [ADDR_LENGTH-1:0]  req_addr,
    input  logic [DATA_LENGTH-1:0]  req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_LENGTH-1:0]  rsp_data,
    output logic                    misalign_exc,
    output logic                    lsu_stall,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic                    mem_we,
    output logic [ADDR_LENGTH-1:0]  mem_addr,
    output logic [3:0]              mem_be,
    output logic [DATA_LENGTH-1:0]  mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [DATA_LENGTH-1:0]  mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    lsu_state_t                 state_q;
    logic                       we_q;
    mem_type                    type_q;
    logic [ADDR_LENGTH-1:0]     addr_q;
    logic [DATA_LENGTH-1:0]     wdata_q;
    logic [2*DATA_LENGTH-1:0]   buf_q, buf_d;
    logic [DATA_LENGTH-1:0]     rsp_data_q;
    logic                       exc_q;

    logic                       accept;
    logic                       split;
    logic [1:0]                 off;
    logic [7:0]                 be64;
    logic [2*DATA_LENGTH-1:0]   wd64;
    logic [ADDR_LENGTH-1:0]     addr0, addr1;
    logic [DATA_LENGTH-1:0]     ext, ext_gen;

    assign off    = addr_q[1:0];
    assign be64   = {4'b0000, lsu_base_be(type_q)} << off;
    assign wd64   = {{DATA_LENGTH{1'b0}}, wdata_q} << {off, 3'b000};
    assign split  = SPLIT_EN && (be64[7:4] != 4'h0);
    assign addr0  = {addr_q[ADDR_LENGTH-1:2], 2'b00};
    assign addr1  = addr0 + ADDR_LENGTH'(4);

    assign req_ready = (state_q == IDLE) || (state_q == RESP);
    assign accept    = req_valid && req_ready;
    assign lsu_stall = !req_ready || accept;

    assign mem_req   = (state_q == REQ0) || (state_q == REQ1);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = (state_q == REQ0) ? addr0 : (state_q == REQ1) ? addr1 : '0;
    assign mem_be    = (state_q == REQ0) ? be64[3:0] : (state_q == REQ1) ? be64[7:4] : 4'h0;
    assign mem_wdata = (state_q == REQ0) ? wd64[DATA_LENGTH-1:0]
                     : (state_q == REQ1) ? wd64[2*DATA_LENGTH-1:DATA_LENGTH] : '0;

    assign rsp_valid    = (state_q == RESP);
    assign rsp_data     = rsp_data_q;
    assign misalign_exc = SPLIT_EN ? 1'b0 : (rsp_valid && exc_q);

    // Merge the returning word now so the extended result can be registered in the same edge.
    always_comb begin
        buf_d = buf_q;
        if (state_q == WAIT0 && mem_rvalid) buf_d[DATA_LENGTH-1:0] = mem_rdata;
        if (state_q == WAIT1 && mem_rvalid) buf_d[2*DATA_LENGTH-1:DATA_LENGTH] = mem_rdata;
    end

    assign ext = buf_d[{1'b0, off, 3'b000} +: DATA_LENGTH];

    DataGen u_datagen (
        .mem_type_i (type_q),
        .data_i     (ext),
        .data_o     (ext_gen)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            type_q     <= MT_B;
            addr_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            rsp_data_q <= '0;
            exc_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    state_q    <= IDLE;
                    rsp_data_q <= '0;
                    exc_q      <= 1'b0;
                    if (accept) begin
                        we_q    <= req_we;
                        type_q  <= req_type;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (!SPLIT_EN && lsu_misaligned(req_type, req_addr[1:0])) begin
                            state_q <= RESP;
                            exc_q   <= 1'b1;
                        end else begin
                            state_q <= REQ0;
                        end
                    end
                end
                REQ0: if (mem_gnt) state_q <= WAIT0;
                WAIT0: if (mem_rvalid) begin
                    buf_q <= buf_d;
                    if (split) begin
                        state_q <= REQ1;
                    end else begin
                        state_q    <= RESP;
                        rsp_data_q <= we_q ? '0 : ext_gen;
                    end
                end
                REQ1: if (mem_gnt) state_q <= WAIT1;
                WAIT1: if (mem_rvalid) begin
                    buf_q      <= buf_d;
                    state_q    <= RESP;
                    rsp_data_q <= we_q ? '0 : ext_gen;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the execute stage and the word-wide data memory port.
- Accepts one access at a time and converts it into one or two word-aligned bus transactions with byte enables.
- Shifts and merges returned words, then sign/zero-extends them through the DataGen sub-module per mem_type.
- Stalls the pipeline until the access completes.

Parameters:
- DATA_LENGTH, 32, datapath width; taken from RVS192_user_parameters, not overridden locally.
- ADDR_LENGTH, 32, byte address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  access accepted this cycle when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_type  in  mem_type  B/H/W/BU/HU (BU/HU on a store are treated as B/H)
- req_addr  in  ADDR_LENGTH  byte address
- req_wdata  in  DATA_LENGTH  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DATA_LENGTH  extended load data; 0 for stores
- misalign_exc  out  1  qualified by rsp_valid
- lsu_stall  out  1  pipeline hold
- mem_req  out  1  bus request
- mem_gnt  in  1  request accepted
- mem_we  out  1  write
- mem_addr  out  ADDR_LENGTH  word address, low 2 bits always 0
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_LENGTH  lane-shifted store data
- mem_rvalid  in  1  read data / write ack; arrives at least 1 cycle after mem_gnt
- mem_rdata  in  DATA_LENGTH  read word

Behaviour:
- Reset values: all outputs 0 except req_ready = 1. State = IDLE; the data buffer is cleared.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE/RESP: req_ready = 1. An accepted request latches we/type/addr/wdata.
  - Misaligned with split disabled: go to RESP.
  - Otherwise: go to REQ0.
  - No request: go to IDLE.
- REQ0/REQ1: mem_req = 1. addr, be, we and wdata are held stable until mem_gnt, then go to WAIT0/WAIT1.
- WAIT0: on mem_rvalid, store rdata into buf[31:0]. Go to REQ1 if split, else RESP.
- WAIT1: on mem_rvalid, store rdata into buf[63:32], then go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle.
- Latency: aligned access with mem_gnt in the first REQ cycle and rvalid 1 cycle later completes with rsp_valid 3 cycles after acceptance.
- lsu_stall = 1 in every state except IDLE and RESP. It is also 1 in the acceptance cycle of a new request.
- Misaligned (off = addr[1:0]):
  - H/HU with off = 3 is misaligned.
  - W with off != 0 is misaligned.
  - B is never misaligned.
- Byte enables: be64 = base << off, with base = 4'h1 (B), 4'h3 (H), 4'hF (W). First access uses be64[3:0] at {addr[31:2],2'b00}. The second access uses be64[7:4] at the first address + 4, with 32-bit wrap-around.
- Store data: wd64 = {32'b0, req_wdata} << (8*off). The first access drives wd64[31:0]; the second drives wd64[63:32].
- Load data: ext = buf >> (8*off), truncated to 32 bits, fed to DataGen with the latched type. rsp_data is registered from the DataGen output.
- Stores: rsp_valid after the final write ack; rsp_data = 0.
- mem_gnt or mem_rvalid outside the matching state is ignored.
- Reset mid-operation: state returns to IDLE immediately. mem_req drops asynchronously. No response is produced for the aborted access.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split into two bus transactions as above; misalign_exc is tied to 0.
- Undefined: a misaligned access makes no bus transaction and goes directly to RESP. It returns rsp_valid = 1, misalign_exc = 1, rsp_data = 0, one cycle after acceptance. REQ1/WAIT1 are never entered.

Decomposition:
- RVS192_package gains the typedef enum lsu_state_t (six states) and the function lsu_misaligned(mem_type, addr[1:0]) for reuse by the hazard unit. mem_type already lives there.
- One sub-module: the existing DataGen, instantiated unchanged for extension.

Test Plan:
- Aligned LW at 0x100, rdata 0x80FF_1234, gnt immediate, rvalid +1 -> mem_addr 0x100, be 4'hF; rsp_data 0x80FF_1234 three cycles after acceptance.
- LB at 0x103, rdata 0x80FF_1234 -> be 4'h8; rsp_data 0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH at 0x102, wdata 0x0000_ABCD -> be 4'hC, mem_wdata 0xABCD_0000, mem_we = 1; rsp_valid after ack, rsp_data 0.
- LW at 0x1FE, split enabled, rdata 0xAABB_CCDD then 0x1122_3344 -> accesses 0x1FC be 4'hC, then 0x200 be 4'h3; rsp_data 0x3344_AABB. Split disabled -> no mem_req; rsp_valid with misalign_exc = 1 one cycle after acceptance.
- mem_gnt held low 5 cycles during REQ0 -> mem_req, mem_addr and mem_be stable throughout; lsu_stall = 1.
- rst_n asserted in WAIT0 -> mem_req = 0 and req_ready = 1 immediately; a late mem_rvalid produces no rsp_valid.
